data_pattern_generator: RTL and testbench

Test-pattern source that feeds the transceiver TX path and, across the serial loop, the downstream data pattern checker. Produces one 64-bit word per accepted beat from a selectable PRBS or fixed pattern, with start/stop, burst length, single-bit error injection and word counting controlled over the same 3-bit-address Avalon-MM CSR slave the checker uses.

---
 rtl/data_pattern_pkg.sv | 107 ++++++++++
 rtl/prbs_lfsr_step64.sv | 47 ++++
 rtl/data_pattern_generator.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_data_pattern_generator.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_pattern_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_pattern_pkg
//  Description : Shared types and constants for the data pattern generator
//                and its checker-side reference model: pattern selector,
//                FSM states, CSR map, CONTROL/STATUS bit positions, PRBS
//                polynomial lengths/taps and small helper functions.
//  Revision    : 1.0  initial release
// ============================================================================
package data_pattern_pkg;

    // Pattern selector as carried in CONTROL[6:4]
    typedef enum logic [2:0] {
        PAT_PRBS7  = 3'd0,
        PAT_PRBS15 = 3'd1,
        PAT_PRBS23 = 3'd2,
        PAT_PRBS31 = 3'd3,
        PAT_CLOCK  = 3'd4,
        PAT_COUNT  = 3'd5,
        PAT_ZERO6  = 3'd6,
        PAT_ZERO7  = 3'd7
    } pattern_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dpg_state_e;

    // CSR word addresses
    localparam logic [2:0] C_ADDR_CONTROL  = 3'd0;
    localparam logic [2:0] C_ADDR_STATUS   = 3'd1;
    localparam logic [2:0] C_ADDR_WCNT_LO  = 3'd2;
    localparam logic [2:0] C_ADDR_WCNT_HI  = 3'd3;
    localparam logic [2:0] C_ADDR_INJ_CNT  = 3'd4;
    localparam logic [2:0] C_ADDR_BURST    = 3'd5;
    localparam logic [2:0] C_ADDR_SEED     = 3'd6;
    localparam logic [2:0] C_ADDR_ID       = 3'd7;

    // CONTROL bit positions
    localparam int C_CTRL_ENABLE_BIT = 0;
    localparam int C_CTRL_SEL_LSB    = 4;
    localparam int C_CTRL_INJECT_BIT = 8;
    localparam int C_CTRL_CLEAR_BIT  = 9;
    // Only enable and pattern_sel are stored; the W1 strobes are never held
    localparam logic [31:0] C_CTRL_STORE_MASK = 32'h0000_0071;

    // STATUS bit positions
    localparam int C_STAT_RUNNING_BIT = 0;
    localparam int C_STAT_DONE_BIT    = 1;
    localparam int C_STAT_PENDING_BIT = 2;

    // PRBS polynomials x^LEN + x^TAP + 1
    localparam int C_PRBS7_LEN  = 7;
    localparam int C_PRBS7_TAP  = 6;
    localparam int C_PRBS15_LEN = 15;
    localparam int C_PRBS15_TAP = 14;
    localparam int C_PRBS23_LEN = 23;
    localparam int C_PRBS23_TAP = 18;
    localparam int C_PRBS31_LEN = 31;
    localparam int C_PRBS31_TAP = 28;

    localparam logic [31:0] C_SEED_RESET   = 32'hFFFF_FFFF;
    localparam logic [63:0] C_CLOCK_PATTERN = 64'hAAAA_AAAA_AAAA_AAAA;

    // Merge write data into a register under a byte mask
    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                r[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return r;
    endfunction

    // State mask for the polynomial selected by sel (non-PRBS -> PRBS7)
    function automatic logic [30:0] prbs_mask(input pattern_sel_e sel);
        logic [30:0] m;
        case (sel)
            PAT_PRBS15: m = 31'h0000_7FFF;
            PAT_PRBS23: m = 31'h007F_FFFF;
            PAT_PRBS31: m = 31'h7FFF_FFFF;
            default:    m = 31'h0000_007F;
        endcase
        return m;
    endfunction

    // Seed masked to the polynomial length; the lock-up state is replaced
    // by all-ones so the LFSR always runs.
    function automatic logic [30:0] prbs_seed(input pattern_sel_e sel,
                                              input logic [31:0]  seed);
        logic [30:0] m;
        logic [30:0] s;
        m = prbs_mask(sel);
        s = seed[30:0] & m;
        if (s == 31'd0) begin
            s = m;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_lfsr_step64.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_lfsr_step64
//  Description : Combinational 64-step advance of a Fibonacci LFSR for the
//                PRBS7/15/23/31 polynomials. Each step computes
//                fb = s[LEN-1] ^ s[TAP-1], emits fb as the next serial bit
//                and shifts fb into s[0]. Output bit 0 is the first step.
//  Ports       : i_poly  - polynomial select (PRBS codes; others -> PRBS7)
//                i_state - current LFSR state (unused upper bits zero)
//                o_state - state after 64 steps
//                o_word  - the 64 bits produced, earliest in bit 0
//  Revision    : 1.0  initial release
// ============================================================================
module prbs_lfsr_step64
    import data_pattern_pkg::*;
(
    input  pattern_sel_e i_poly,
    input  logic [30:0]  i_state,
    output logic [30:0]  o_state,
    output logic [63:0]  o_word
);

    logic [30:0] w_mask;
    logic [30:0] w_s;
    logic        w_fb;

    assign w_mask = prbs_mask(i_poly);

    always_comb begin
        w_s    = i_state & w_mask;
        o_word = '0;
        w_fb   = 1'b0;
        for (int k = 0; k < 64; k++) begin
            case (i_poly)
                PAT_PRBS15: w_fb = w_s[C_PRBS15_LEN-1] ^ w_s[C_PRBS15_TAP-1];
                PAT_PRBS23: w_fb = w_s[C_PRBS23_LEN-1] ^ w_s[C_PRBS23_TAP-1];
                PAT_PRBS31: w_fb = w_s[C_PRBS31_LEN-1] ^ w_s[C_PRBS31_TAP-1];
                default:    w_fb = w_s[C_PRBS7_LEN-1]  ^ w_s[C_PRBS7_TAP-1];
            endcase
            o_word[k] = w_fb;
            w_s       = {w_s[29:0], w_fb} & w_mask;
        end
        o_state = w_s;
    end

endmodule
`default_nettype wire

// File: rtl/data_pattern_generator.sv
`default_nettype none
// ============================================================================
//  Module      : data_pattern_generator
//  Description : 64-bit test-pattern source (PRBS7/15/23/31, clock, counter,
//                zeros) with start/stop, burst length, word counting and an
//                optional single-bit error injector, controlled through a
//                3-bit-address Avalon-MM CSR slave.
//  Build macro : DPG_ERR_INJECT_EN - enables inject_once / INJECT_COUNT.
//  Ports       : csr_clk_clk           - clock for CSR and datapath
//                reset_reset           - synchronous active-high reset
//                csr_slave_address     - CSR word address
//                csr_slave_write/read  - strobes (read latency 1)
//                csr_slave_byteenable  - byte write enables
//                csr_slave_writedata   - write data
//                csr_slave_readdata    - registered read data
//                aso_data/valid/ready  - Avalon-ST pattern output
//  Revision    : 1.0  initial release
// ============================================================================
module data_pattern_generator
    import data_pattern_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = 32'h4450_4730,
    parameter int          DATA_W   = 64
) (
    input  logic              csr_clk_clk,
    input  logic              reset_reset,
    input  logic [2:0]        csr_slave_address,
    input  logic              csr_slave_write,
    input  logic              csr_slave_read,
    input  logic [3:0]        csr_slave_byteenable,
    input  logic [31:0]       csr_slave_writedata,
    output logic [31:0]       csr_slave_readdata,
    output logic [DATA_W-1:0] aso_data,
    output logic              aso_valid,
    input  logic              aso_ready
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    dpg_state_e   state_q, state_d;

    logic [31:0]  ctrl_q,      ctrl_d;
    logic [31:0]  seed_q,      seed_d;
    logic [31:0]  burst_cfg_q, burst_cfg_d;   // BURST_LEN register
    logic [63:0]  word_cnt_q,  word_cnt_d;
    logic [31:0]  shadow_q,    shadow_d;
    logic [31:0]  readdata_q,  readdata_d;

    pattern_sel_e pat_sel_q,   pat_sel_d;     // latched in IDLE
    logic [31:0]  burst_len_q, burst_len_d;   // latched in IDLE
    logic [31:0]  burst_cnt_q, burst_cnt_d;
    logic [30:0]  lfsr_q,      lfsr_d;
    logic [63:0]  cnt_q,       cnt_d;         // counter pattern
    logic [63:0]  data_q,      data_d;

    // ------------------------------------------------------------------
    // Decodes
    // ------------------------------------------------------------------
    logic         w_ctrl_wr;
    logic         w_clear;
    logic         w_accept;
    logic         w_enable_next;
    pattern_sel_e w_sel_next;
    logic         w_inject_pending;
    logic [31:0]  w_inject_cnt;

    assign w_ctrl_wr = csr_slave_write && (csr_slave_address == C_ADDR_CONTROL);
    assign w_clear   = w_ctrl_wr && csr_slave_byteenable[1]
                       && csr_slave_writedata[C_CTRL_CLEAR_BIT];
    assign w_accept  = (state_q == ST_RUN) && aso_ready;

    // The FSM acts on CONTROL as it will be after this edge, so a write of
    // enable in cycle N starts the stream at edge N+1.
    assign w_enable_next = ctrl_d[C_CTRL_ENABLE_BIT];
    assign w_sel_next    = pattern_sel_e'(ctrl_d[C_CTRL_SEL_LSB +: 3]);

    // ------------------------------------------------------------------
    // CSR registers
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d      = ctrl_q;
        seed_d      = seed_q;
        burst_cfg_d = burst_cfg_q;
        if (csr_slave_write) begin
            case (csr_slave_address)
                C_ADDR_CONTROL: ctrl_d = apply_be(ctrl_q, csr_slave_writedata,
                                                  csr_slave_byteenable) & C_CTRL_STORE_MASK;
                C_ADDR_BURST:   burst_cfg_d = apply_be(burst_cfg_q, csr_slave_writedata,
                                                       csr_slave_byteenable);
                C_ADDR_SEED:    seed_d = apply_be(seed_q, csr_slave_writedata,
                                                  csr_slave_byteenable);
                default: ;
            endcase
        end

        // Clear has priority over a coincident accepted beat
        word_cnt_d = word_cnt_q;
        if (w_clear) begin
            word_cnt_d = 64'd0;
        end else if (w_accept) begin
            word_cnt_d = word_cnt_q + 64'd1;
        end

        // Reading LO freezes HI so a 64-bit read pair is coherent
        shadow_d = shadow_q;
        if (csr_slave_read && (csr_slave_address == C_ADDR_WCNT_LO)) begin
            shadow_d = word_cnt_q[63:32];
        end

        readdata_d = 32'd0;
        if (csr_slave_read) begin
            case (csr_slave_address)
                C_ADDR_CONTROL: readdata_d = ctrl_q;
                C_ADDR_STATUS: begin
                    readdata_d[C_STAT_RUNNING_BIT] = (state_q == ST_RUN);
                    readdata_d[C_STAT_DONE_BIT]    = (state_q == ST_DONE);
                    readdata_d[C_STAT_PENDING_BIT] = w_inject_pending;
                end
                C_ADDR_WCNT_LO: readdata_d = word_cnt_q[31:0];
                C_ADDR_WCNT_HI: readdata_d = shadow_q;
                C_ADDR_INJ_CNT: readdata_d = w_inject_cnt;
                C_ADDR_BURST:   readdata_d = burst_cfg_q;
                C_ADDR_SEED:    readdata_d = seed_q;
                default:        readdata_d = ID_VALUE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pattern source. In IDLE the step function is fed the freshly masked
    // seed so the first word is ready at the IDLE->RUN edge; in RUN it is
    // fed the state that follows the word currently on aso_data.
    // ------------------------------------------------------------------
    pattern_sel_e w_step_sel;
    logic [30:0]  w_step_in;
    logic [30:0]  w_step_out;
    logic [63:0]  w_step_word;
    logic [63:0]  w_src_word;

    assign w_step_sel = (state_q == ST_IDLE) ? w_sel_next : pat_sel_q;
    assign w_step_in  = (state_q == ST_IDLE) ? prbs_seed(w_sel_next, seed_d) : lfsr_q;

    prbs_lfsr_step64 u_step (
        .i_poly  (w_step_sel),
        .i_state (w_step_in),
        .o_state (w_step_out),
        .o_word  (w_step_word)
    );

    always_comb begin
        case (w_step_sel)
            PAT_PRBS7, PAT_PRBS15,
            PAT_PRBS23, PAT_PRBS31: w_src_word = w_step_word;
            PAT_CLOCK:              w_src_word = C_CLOCK_PATTERN;
            PAT_COUNT:              w_src_word = (state_q == ST_IDLE) ? 64'd0 : cnt_q;
            default:                w_src_word = 64'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pat_sel_d   = pat_sel_q;
        burst_len_d = burst_len_q;
        burst_cnt_d = burst_cnt_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        data_d      = data_q;

        case (state_q)
            ST_IDLE: begin
                pat_sel_d   = w_sel_next;
                burst_len_d = burst_cfg_d;
                burst_cnt_d = 32'd0;
                lfsr_d      = w_step_in;
                cnt_d       = 64'd0;
                if (w_enable_next) begin
                    state_d = ST_RUN;
                    data_d  = w_src_word;
                    lfsr_d  = w_step_out;
                    cnt_d   = 64'd1;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    data_d      = w_src_word;
                    lfsr_d      = w_step_out;
                    cnt_d       = cnt_q + 64'd1;
                    burst_cnt_d = burst_cnt_q + 32'd1;
                    if ((burst_len_q != 32'd0) && (burst_cnt_q + 32'd1 == burst_len_q)) begin
                        state_d = ST_DONE;
                    end
                end
                if (!w_enable_next) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!w_enable_next) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge csr_clk_clk) begin
        if (reset_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge csr_clk_clk) begin
        if (reset_reset) begin
            ctrl_q      <= 32'd0;
            seed_q      <= C_SEED_RESET;
            burst_cfg_q <= 32'd0;
            word_cnt_q  <= 64'd0;
            shadow_q    <= 32'd0;
            readdata_q  <= 32'd0;
            pat_sel_q   <= PAT_PRBS7;
            burst_len_q <= 32'd0;
            burst_cnt_q <= 32'd0;
            lfsr_q      <= 31'd0;
            cnt_q       <= 64'd0;
            data_q      <= 64'd0;
        end else begin
            ctrl_q      <= ctrl_d;
            seed_q      <= seed_d;
            burst_cfg_q <= burst_cfg_d;
            word_cnt_q  <= word_cnt_d;
            shadow_q    <= shadow_d;
            readdata_q  <= readdata_d;
            pat_sel_q   <= pat_sel_d;
            burst_len_q <= burst_len_d;
            burst_cnt_q <= burst_cnt_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
        end
    end

    // ------------------------------------------------------------------
    // Error injection
    // ------------------------------------------------------------------
`ifdef DPG_ERR_INJECT_EN
    logic        inject_pending_q, inject_pending_d;
    logic [31:0] inject_cnt_q,     inject_cnt_d;
    logic        w_inject_req;

    assign w_inject_req = w_ctrl_wr && csr_slave_byteenable[1]
                          && csr_slave_writedata[C_CTRL_INJECT_BIT];

    always_comb begin
        // A request arriving while one is pending is dropped
        if (inject_pending_q) begin
            inject_pending_d = !w_accept;
        end else begin
            inject_pending_d = w_inject_req;
        end

        inject_cnt_d = inject_cnt_q;
        if (w_clear) begin
            inject_cnt_d = 32'd0;
        end else if (w_accept && inject_pending_q && (inject_cnt_q != 32'hFFFF_FFFF)) begin
            inject_cnt_d = inject_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge csr_clk_clk) begin
        if (reset_reset) begin
            inject_pending_q <= 1'b0;
            inject_cnt_q     <= 32'd0;
        end else begin
            inject_pending_q <= inject_pending_d;
            inject_cnt_q     <= inject_cnt_d;
        end
    end

    assign w_inject_pending = inject_pending_q;
    assign w_inject_cnt     = inject_cnt_q;
`else
    assign w_inject_pending = 1'b0;
    assign w_inject_cnt     = 32'd0;
`endif

    // ------------------------------------------------------------------
    // Outputs. The flip is applied on the way out so the pattern state
    // itself is never disturbed.
    // ------------------------------------------------------------------
    logic w_flip;
    assign w_flip = w_inject_pending && (state_q == ST_RUN);

    assign aso_valid          = (state_q == ST_RUN);
    assign aso_data           = data_q ^ {63'd0, w_flip};
    assign csr_slave_readdata = readdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_pattern_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_pattern_generator
//  Description : Self-checking bench for data_pattern_generator. A vector
//                table covers reset values and byte-masked CSR access;
//                hand-written sequences cover streaming, bursts, PRBS
//                back-pressure, clear/accept collision, reset mid-burst and
//                error injection (expectations follow DPG_ERR_INJECT_EN).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_pattern_generator;

    logic        clk;
    logic        rst;
    logic [2:0]  addr;
    logic        wr;
    logic        rd;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [63:0] aso_data;
    logic        aso_valid;
    logic        aso_ready;

    data_pattern_generator dut (
        .csr_clk_clk          (clk),
        .reset_reset          (rst),
        .csr_slave_address    (addr),
        .csr_slave_write      (wr),
        .csr_slave_read       (rd),
        .csr_slave_byteenable (be),
        .csr_slave_writedata  (wdata),
        .csr_slave_readdata   (rdata),
        .aso_data             (aso_data),
        .aso_valid            (aso_valid),
        .aso_ready            (aso_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // All bus activity is applied and sampled at the falling edge
    task automatic csr_write(input logic [2:0] a, input logic [3:0] b, input logic [31:0] d);
        @(negedge clk);
        addr = a; be = b; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        d  = rdata;
    endtask

    // Reference Fibonacci LFSR: fb = s[len-1]^s[tap-1], fb is the next
    // serial bit (word bit 0 first) and is shifted into s[0].
    logic [30:0] m_state;
    logic [63:0] m_word;

    task automatic model_next(input int len, input int tap);
        logic [30:0] mask;
        logic        fb;
        mask = 31'h7FFF_FFFF >> (31 - len);
        for (int k = 0; k < 64; k++) begin
            fb        = m_state[len-1] ^ m_state[tap-1];
            m_word[k] = fb;
            m_state   = {m_state[29:0], fb} & mask;
        end
    endtask

    typedef struct {
        bit          is_wr;
        logic [2:0]  a;
        logic [3:0]  b;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [18];

    int          plen [3];
    int          ptap [3];
    logic [31:0] r;
    int          beats;
    logic [63:0] exp_inj;

    initial begin
        tbl[0]  = '{0, 3'd7, 4'h0, 32'h0,         32'h4450_4730};
        tbl[1]  = '{0, 3'd6, 4'h0, 32'h0,         32'hFFFF_FFFF};
        tbl[2]  = '{0, 3'd0, 4'h0, 32'h0,         32'h0};
        tbl[3]  = '{0, 3'd1, 4'h0, 32'h0,         32'h0};
        tbl[4]  = '{0, 3'd2, 4'h0, 32'h0,         32'h0};
        tbl[5]  = '{0, 3'd4, 4'h0, 32'h0,         32'h0};
        tbl[6]  = '{0, 3'd5, 4'h0, 32'h0,         32'h0};
        tbl[7]  = '{1, 3'd6, 4'h3, 32'h1234_5678, 32'h0};
        tbl[8]  = '{0, 3'd6, 4'h0, 32'h0,         32'hFFFF_5678};
        tbl[9]  = '{1, 3'd5, 4'h8, 32'hAB00_00CD, 32'h0};
        tbl[10] = '{0, 3'd5, 4'h0, 32'h0,         32'hAB00_0000};
        tbl[11] = '{1, 3'd5, 4'hF, 32'h0,         32'h0};
        tbl[12] = '{0, 3'd5, 4'h0, 32'h0,         32'h0};
        tbl[13] = '{1, 3'd7, 4'hF, 32'h0,         32'h0};
        tbl[14] = '{0, 3'd7, 4'h0, 32'h0,         32'h4450_4730};
        tbl[15] = '{1, 3'd0, 4'h1, 32'hFFFF_FFF0, 32'h0};
        tbl[16] = '{0, 3'd0, 4'h0, 32'h0,         32'h0000_0070};
        tbl[17] = '{1, 3'd0, 4'hF, 32'h0,         32'h0};
        plen = '{7, 15, 23};
        ptap = '{6, 14, 18};

        rst = 1'b1; addr = '0; wr = 1'b0; rd = 1'b0; be = '0; wdata = '0; aso_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_valid", {63'd0, aso_valid}, 64'd0);
        check("reset_data", aso_data, 64'd0);
        check("reset_rdata", {32'd0, rdata}, 64'd0);

        // ---------------- CSR vector table ----------------
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].is_wr) begin
                csr_write(tbl[i].a, tbl[i].b, tbl[i].d);
            end else begin
                csr_read(tbl[i].a, r);
                check($sformatf("tbl[%0d]", i), {32'd0, r}, {32'd0, tbl[i].exp});
            end
        end
        @(negedge clk);
        check("rdata_idle_zero", {32'd0, rdata}, 64'd0);
        csr_write(3'd6, 4'hF, 32'hFFFF_FFFF);

        // ---------------- counter pattern, full throughput ----------------
        aso_ready = 1'b1;
        csr_write(3'd0, 4'hF, 32'h51);
        check("cnt_first_valid", {63'd0, aso_valid}, 64'd1);
        check("cnt_word0", aso_data, 64'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("cnt_word%0d", k), aso_data, 64'(k));
        end
        csr_write(3'd0, 4'hF, 32'h50);          // word 6 accepted with the disable
        check("disable_valid", {63'd0, aso_valid}, 64'd0);
        aso_ready = 1'b0;
        csr_read(3'd2, r);
        check("cnt_wordcount", {32'd0, r}, 64'd7);

        // ---------------- clock pattern burst of 4 ----------------
        csr_write(3'd0, 4'hF, 32'h200);
        csr_write(3'd5, 4'hF, 32'd4);
        aso_ready = 1'b1;
        csr_write(3'd0, 4'hF, 32'h41);
        beats = 0;
        for (int i = 0; i < 10; i++) begin
            if (aso_valid) begin
                beats++;
                check("burst_data", aso_data, 64'hAAAA_AAAA_AAAA_AAAA);
            end
            @(negedge clk);
        end
        aso_ready = 1'b0;
        check("burst_beats", 64'(beats), 64'd4);
        csr_read(3'd1, r);
        check("burst_status", {32'd0, r}, 64'h2);
        csr_read(3'd2, r);
        check("burst_wordcount", {32'd0, r}, 64'd4);
        csr_write(3'd0, 4'hF, 32'h0);
        csr_write(3'd5, 4'hF, 32'h0);

        // ---------------- PRBS7/15/23 from a zero seed (all-ones) ----------------
        csr_write(3'd6, 4'hF, 32'h0);
        for (int p = 0; p < 3; p++) begin
            m_state = 31'h7FFF_FFFF >> (31 - plen[p]);
            model_next(plen[p], ptap[p]);
            aso_ready = 1'b1;
            csr_write(3'd0, 4'hF, 32'((p << 4) | 1));
            for (int j = 0; j < 3; j++) begin
                check($sformatf("prbs_p%0d_w%0d", p, j), aso_data, m_word);
                model_next(plen[p], ptap[p]);
                @(negedge clk);
            end
            aso_ready = 1'b0;
            csr_write(3'd0, 4'hF, 32'h0);
        end

        // ---------------- PRBS31, seed 1, 5-cycle stall ----------------
        csr_write(3'd6, 4'hF, 32'h1);
        m_state = 31'd1;
        model_next(31, 28);
        aso_ready = 1'b1;
        csr_write(3'd0, 4'hF, 32'h31);
        for (int c = 0; c < 15; c++) begin
            aso_ready = (c >= 4 && c < 9) ? 1'b0 : 1'b1;
            check($sformatf("prbs31_c%0d", c), aso_data, m_word);
            if (aso_ready) model_next(31, 28);
            @(negedge clk);
        end
        aso_ready = 1'b0;
        csr_write(3'd0, 4'hF, 32'h0);
        csr_write(3'd6, 4'hF, 32'hFFFF_FFFF);

        // ---------------- clear_counts coincident with an accepted beat ----------------
        aso_ready = 1'b1;
        csr_write(3'd0, 4'hF, 32'h51);
        @(negedge clk);
        @(negedge clk);
        addr = 3'd0; be = 4'hF; wdata = 32'h251; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; aso_ready = 1'b0;
        csr_read(3'd2, r);
        check("clear_wins_lo", {32'd0, r}, 64'd0);
        csr_read(3'd3, r);
        check("clear_wins_hi", {32'd0, r}, 64'd0);

        // ---------------- reset mid-burst ----------------
        check("pre_reset_valid", {63'd0, aso_valid}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_valid", {63'd0, aso_valid}, 64'd0);
        rst = 1'b0;
        csr_read(3'd1, r);
        check("midreset_status", {32'd0, r}, 64'd0);
        csr_read(3'd0, r);
        check("midreset_control", {32'd0, r}, 64'd0);

        // ---------------- error injection on the counter pattern ----------------
        csr_write(3'd0, 4'hF, 32'h51);
        aso_ready = 1'b1;
        repeat (3) @(negedge clk);
        aso_ready = 1'b0;
        check("inj_pre_word", aso_data, 64'd3);
        csr_write(3'd0, 4'hF, 32'h151);
`ifdef DPG_ERR_INJECT_EN
        exp_inj = 64'd2;
`else
        exp_inj = 64'd3;
`endif
        check("inj_word", aso_data, exp_inj);
        csr_read(3'd1, r);
`ifdef DPG_ERR_INJECT_EN
        check("inj_status_pending", {32'd0, r}, 64'h5);
`else
        check("inj_status_pending", {32'd0, r}, 64'h1);
`endif
        aso_ready = 1'b1;
        @(negedge clk);
        aso_ready = 1'b0;
        check("inj_next_word", aso_data, 64'd4);
        csr_read(3'd4, r);
`ifdef DPG_ERR_INJECT_EN
        check("inj_count", {32'd0, r}, 64'd1);
`else
        check("inj_count", {32'd0, r}, 64'd0);
`endif
        csr_read(3'd1, r);
        check("inj_status_after", {32'd0, r}, 64'h1);
        csr_write(3'd0, 4'hF, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
